// File: rtl/bridge_rx.sv
// bridge_rx: host-to-bus half of the UART bridge.
//
// Parses ASCII request messages arriving one byte at a time from uart_rx
// and emits one bus request per complete, well-formed message:
//   read  : 'R' + ADDR_WIDTH/4 hex digits + CR|LF
//   write : 'W' + ADDR_WIDTH/4 hex digits + DATA_WIDTH/4 hex digits + CR|LF
// Hex digits accept upper and lower case and shift in MSB-first.
// A byte that is illegal at its position drops the partial message;
// an aborting 'R' or 'W' immediately starts a new message.
//
// Ports:
//   clk      system clock, all logic on rising edge
//   rst      synchronous reset, active high
//   data_i   received byte from uart_rx
//   valid_i  data_i valid this cycle (one pulse per byte)
//   addr_o   decoded request address (held until the next request)
//   data_o   decoded write data, 0 for reads (held until the next request)
//   rw_o     1 = write, 0 = read (held until the next request)
//   valid_o  one-cycle strobe marking a new request on addr_o/data_o/rw_o
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for 'R' or 'W'; everything else (incl. CR/LF) ignored
// ADDR  | collecting address hex digits
// DATA  | collecting write-data hex digits (writes only)
// TERM  | all digits collected; expecting CR or LF to commit

module bridge_rx #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            data_i,
  input  logic                  valid_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  rw_o,
  output logic                  valid_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_TERM = 2'd3;

  localparam int ADDR_DIGITS = ADDR_WIDTH / 4;
  localparam int DATA_DIGITS = DATA_WIDTH / 4;
  localparam int MAX_DIGITS  = (ADDR_DIGITS > DATA_DIGITS) ? ADDR_DIGITS : DATA_DIGITS;
  localparam int CW          = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;

  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_DIGITS - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_DIGITS - 1);

  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  logic [ADDR_WIDTH-1:0] addr_sr;
  logic [DATA_WIDTH-1:0] data_sr;
  logic                  rw_q;

  // Byte classification
  logic       is_hex;
  logic [3:0] nibble;
  logic       is_cmd;
  logic       is_write_cmd;
  logic       is_term;

  always_comb begin
    is_hex = 1'b0;
    nibble = 4'h0;
    if (data_i >= 8'h30 && data_i <= 8'h39) begin
      is_hex = 1'b1;
      nibble = data_i[3:0];
    end else if ((data_i >= 8'h41 && data_i <= 8'h46) ||
                 (data_i >= 8'h61 && data_i <= 8'h66)) begin
      // 'A'..'F' and 'a'..'f' share the low nibble 1..6
      is_hex = 1'b1;
      nibble = data_i[3:0] + 4'd9;
    end
  end

  assign is_write_cmd = (data_i == 8'h57);
  assign is_cmd       = (data_i == 8'h52) || is_write_cmd;
  assign is_term      = (data_i == 8'h0D) || (data_i == 8'h0A);

  // Shifted field values; the widened concat keeps this legal for 4-bit fields
  logic [ADDR_WIDTH+3:0] addr_ext;
  logic [DATA_WIDTH+3:0] data_ext;

  assign addr_ext = {addr_sr, nibble};
  assign data_ext = {data_sr, nibble};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_sr <= '0;
      data_sr <= '0;
      rw_q    <= 1'b0;
      addr_o  <= '0;
      data_o  <= '0;
      rw_o    <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (valid_i) begin
        case (state)
          S_IDLE: begin
            if (is_cmd) begin
              state   <= S_ADDR;
              rw_q    <= is_write_cmd;
              cnt     <= '0;
              addr_sr <= '0;
              data_sr <= '0;
            end
          end

          S_ADDR: begin
            if (is_hex) begin
              addr_sr <= addr_ext[ADDR_WIDTH-1:0];
              if (cnt == ADDR_LAST) begin
                cnt   <= '0;
                state <= rw_q ? S_DATA : S_TERM;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end else if (is_cmd) begin
              // resync: the aborting byte opens a new message
              state   <= S_ADDR;
              rw_q    <= is_write_cmd;
              cnt     <= '0;
              addr_sr <= '0;
              data_sr <= '0;
            end else begin
              state <= S_IDLE;
            end
          end

          S_DATA: begin
            if (is_hex) begin
              data_sr <= data_ext[DATA_WIDTH-1:0];
              if (cnt == DATA_LAST) begin
                cnt   <= '0;
                state <= S_TERM;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end else if (is_cmd) begin
              state   <= S_ADDR;
              rw_q    <= is_write_cmd;
              cnt     <= '0;
              addr_sr <= '0;
              data_sr <= '0;
            end else begin
              state <= S_IDLE;
            end
          end

          S_TERM: begin
            if (is_term) begin
              addr_o  <= addr_sr;
              data_o  <= rw_q ? data_sr : '0;
              rw_o    <= rw_q;
              valid_o <= 1'b1;
              state   <= S_IDLE;
            end else if (is_cmd) begin
              state   <= S_ADDR;
              rw_q    <= is_write_cmd;
              cnt     <= '0;
              addr_sr <= '0;
              data_sr <= '0;
            end else begin
              state <= S_IDLE;
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
